test_result_monitor: RTL and testbench

//  Synthesizable pass/fail monitor sitting directly downstream of Core in the riscv-tests benches.

---
 rtl/test_result_monitor.sv | 138 +++++++++++++
 tb/tb_test_result_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/test_result_monitor.sv
// ==========================================================================================
// test_result_monitor: riscv-tests PASS/FAIL/TIMEOUT verdict monitor; PC_MATCH_EN enables pc/gp check. Rev 1.0
// ==========================================================================================
`default_nettype none

module test_result_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter logic [31:0] PASS_PC     = 32'h0000_0044,
  parameter logic [31:0] TIMEOUT     = 32'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [31:0] pc,
  input  logic [31:0] gp,
  output logic        done,
  output logic        done_pulse,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PASS_S    = 3'd2,
    FAIL_S    = 3'd3,
    TIMEOUT_S = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic        done_pulse_q, done_pulse_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        timeout_q, timeout_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic [31:0] cycle_count_q, cycle_count_d;

  logic tohost_hit;
  logic pc_hit;

  assign tohost_hit = st_valid && (st_addr == TOHOST_ADDR) && (st_data != 32'd0);

`ifdef PC_MATCH_EN
  assign pc_hit = (pc == PASS_PC);
`else
  logic unused_pc_gp;
  assign unused_pc_gp = ^{pc, gp};
  assign pc_hit       = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    done_pulse_d  = 1'b0;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    fail_code_d   = fail_code_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (tohost_hit) begin
          done_d       = 1'b1;
          done_pulse_d = 1'b1;
          if (st_data == 32'd1) begin
            state_d = PASS_S;
            pass_d  = 1'b1;
          end else begin
            state_d = FAIL_S;
            fail_d  = 1'b1;
            // An even nonzero value is not a legal riscv-tests verdict encoding
            fail_code_d = st_data[0] ? st_data[31:1] : 31'h7FFF_FFFF;
          end
        end else if (pc_hit) begin
          done_d       = 1'b1;
          done_pulse_d = 1'b1;
          if (gp == 32'd1) begin
            state_d = PASS_S;
            pass_d  = 1'b1;
          end else begin
            state_d     = FAIL_S;
            fail_d      = 1'b1;
            fail_code_d = gp[31:1];
          end
        end else if (cycle_count_q == (TIMEOUT - 32'd1)) begin
          state_d      = TIMEOUT_S;
          done_d       = 1'b1;
          done_pulse_d = 1'b1;
          timeout_d    = 1'b1;
        end else if (cycle_count_q != 32'hFFFF_FFFF) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      done_pulse_q  <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= 31'd0;
      cycle_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      done_pulse_q  <= done_pulse_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
      fail_code_q   <= fail_code_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign done        = done_q;
  assign done_pulse  = done_pulse_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_test_result_monitor.sv
// ==========================================================================================
// tb_test_result_monitor: table-driven checks of test_result_monitor verdicts. Rev 1.0
// ==========================================================================================
`default_nettype none

module tb_test_result_monitor;

  localparam logic [31:0] C_TOHOST = 32'h0000_1000;
`ifdef PC_MATCH_EN
  localparam bit PCM = 1'b1;
`else
  localparam bit PCM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] gp = 32'd0;
  logic        done, done_pulse, pass, fail, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  test_result_monitor #(
    .TOHOST_ADDR(C_TOHOST),
    .PASS_PC    (32'h0000_0044),
    .TIMEOUT    (32'd20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .pc         (pc),
    .gp         (gp),
    .done       (done),
    .done_pulse (done_pulse),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .fail_code  (fail_code),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wait_cycles;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc_v;
    logic [31:0] gp_v;
    logic        e_done;
    logic        e_pass;
    logic        e_fail;
    logic        e_to;
    logic [30:0] e_fc;
    logic [31:0] e_cc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0;
    st_addr  = 32'd0;
    st_data  = 32'd0;
    pc       = 32'd0;
    gp       = 32'd0;
  endtask

  task automatic do_reset(input int idx);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", idx, {31'd0, done}, 32'd0);
    check("rst_flags", idx, {29'd0, pass, fail, timeout}, 32'd0);
    check("rst_cc", idx, cycle_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive_store(input logic [31:0] d);
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = C_TOHOST;
    st_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    do_reset(idx);
    @(posedge clk);
    repeat (v.wait_cycles) @(posedge clk);
    @(negedge clk);
    st_valid = v.valid;
    st_addr  = v.addr;
    st_data  = v.data;
    pc       = v.pc_v;
    gp       = v.gp_v;
    @(posedge clk);
    #1;
    check("done", idx, {31'd0, done}, {31'd0, v.e_done});
    check("pulse", idx, {31'd0, done_pulse}, {31'd0, v.e_done});
    check("flags", idx, {29'd0, pass, fail, timeout}, {29'd0, v.e_pass, v.e_fail, v.e_to});
    check("fail_code", idx, {1'b0, fail_code}, {1'b0, v.e_fc});
    check("cycle_count", idx, cycle_count, v.e_cc);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    check("pulse_off", idx, {31'd0, done_pulse}, 32'd0);
    check("done_hold", idx, {31'd0, done}, {31'd0, v.e_done});
    check("flags_hold", idx, {29'd0, pass, fail, timeout}, {29'd0, v.e_pass, v.e_fail, v.e_to});
  endtask

  initial begin
    // wait, valid, addr, data, pc, gp, done, pass, fail, to, fail_code, cycle_count
    vecs[0] = '{10, 1'b1, C_TOHOST, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd10};
    vecs[1] = '{3, 1'b1, C_TOHOST, 32'h7, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 31'd3, 32'd3};
    vecs[2] = '{5, 1'b1, C_TOHOST, 32'h2, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 31'h7FFF_FFFF, 32'd5};
    vecs[3] = '{0, 1'b1, C_TOHOST, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 31'h7FFF_FFFF, 32'd0};
    vecs[4] = '{4, 1'b1, 32'h0000_1001, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd5};
    vecs[5] = '{2, 1'b0, C_TOHOST, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd3};
    vecs[6] = '{7, 1'b1, C_TOHOST, 32'h3, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 31'd1, 32'd7};
    vecs[7] = '{6, 1'b0, 32'h0, 32'h0, 32'h44, 32'h9, PCM, 1'b0, PCM, 1'b0,
                PCM ? 31'd4 : 31'd0, PCM ? 32'd6 : 32'd7};
    vecs[8] = '{2, 1'b1, C_TOHOST, 32'h5, 32'h44, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 31'd2, 32'd2};
    vecs[9] = '{8, 1'b0, 32'h0, 32'h0, 32'h44, 32'h1, PCM, PCM, 1'b0, 1'b0,
                31'd0, PCM ? 32'd8 : 32'd9};

    for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

    // Terminal FAIL ignores a later passing store
    do_reset(20);
    @(posedge clk);
    drive_store(32'h7);
    check("seq_fail", 20, {31'd0, fail}, 32'd1);
    drive_store(32'h1);
    @(negedge clk);
    idle_inputs();
    #1;
    check("seq_sticky_pass", 20, {31'd0, pass}, 32'd0);
    check("seq_sticky_fail", 20, {31'd0, fail}, 32'd1);
    check("seq_sticky_fc", 20, {1'b0, fail_code}, 32'd3);

    // Timeout after 20 RUN cycles, cycle_count frozen at 19
    do_reset(21);
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1;
    check("to_before", 21, {31'd0, timeout}, 32'd0);
    check("to_before_cc", 21, cycle_count, 32'd19);
    @(posedge clk);
    #1;
    check("to_flag", 21, {29'd0, pass, fail, timeout}, 32'd1);
    check("to_pulse", 21, {31'd0, done_pulse}, 32'd1);
    check("to_cc", 21, cycle_count, 32'd19);
    drive_store(32'h1);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("to_sticky", 21, {29'd0, pass, fail, timeout}, 32'd1);
    check("to_cc_hold", 21, cycle_count, 32'd19);
    check("to_pulse_off", 21, {31'd0, done_pulse}, 32'd0);

    // Asynchronous reset mid-run, then zero store ignored and even store malformed
    do_reset(22);
    @(posedge clk);
    repeat (4) @(posedge clk);
    drive_store(32'h1);
    check("ar_pass", 22, {31'd0, pass}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    check("ar_clear_flags", 22, {28'd0, done, pass, fail, timeout}, 32'd0);
    check("ar_clear_cc", 22, cycle_count, 32'd0);
    check("ar_clear_pulse", 22, {31'd0, done_pulse}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    drive_store(32'h0);
    check("ar_zero_ignored", 22, {31'd0, done}, 32'd0);
    check("ar_zero_cc", 22, cycle_count, 32'd1);
    drive_store(32'h2);
    check("ar_even_fail", 22, {29'd0, pass, fail, timeout}, 32'd2);
    check("ar_even_fc", 22, {1'b0, fail_code}, 32'h7FFF_FFFF);
    check("ar_even_cc", 22, cycle_count, 32'd1);
    @(negedge clk);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
